// File: rtl/mcrd_pkg.sv
// Shared definitions for the multi-channel run detector
// and the status bank that consumes its counters.
package mcrd_pkg;

  typedef enum logic {
    OUT_MEALY = 1'b0,
    OUT_REG   = 1'b1
  } out_mode_e;

  // Unsigned add clamped to the largest w-bit value.
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << w) - 33'd1;
    return (sum > max) ? max[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/run_len_channel.sv
// One serial channel: saturating run counter, hit detect,
// captured run length and optional output register.
module run_len_channel
  import mcrd_pkg::*;
#(
  parameter int MIN_RUN = 1,
  parameter int CNT_W   = 4,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_valid,
  input  logic             x_bit,
  output logic             hit,
  output logic             y,
  output logic [CNT_W-1:0] run_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_RUN);

  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;

  always_comb begin
    hit       = x_valid & ~x_bit & (run_cnt_q >= MIN_V);
    run_cnt_d = run_cnt_q;
    run_len_d = run_len_q;
    if (x_valid) begin
      if (!x_bit)
        run_cnt_d = '0;
      else if (run_cnt_q != CNT_MAX)
        run_cnt_d = run_cnt_q + 1'b1;
    end
    if (hit)
      run_len_d = run_cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cnt_q <= '0;
      run_len_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      run_len_q <= run_len_d;
    end
  end

  assign run_len = run_len_q;

  if (REG_OUT == bit'(OUT_REG)) begin : g_reg
    logic y_q, y_d;
    assign y_d = hit;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) y_q <= 1'b0;
      else        y_q <= y_d;
    end
    assign y = y_q;
  end else begin : g_mealy
    assign y = hit;
  end

endmodule

// File: rtl/multi_channel_run_detector.sv
// Detects a 0 after a run of >= MIN_RUN 1s on each channel
// and keeps a shared saturating count of detections.
module multi_channel_run_detector
  import mcrd_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MIN_RUN  = 1,
  parameter int CNT_W    = 4,
  parameter bit REG_OUT  = 1'b0,
  parameter int HIT_W    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      x_valid,
  input  logic [CHANNELS-1:0]       x_in,
  input  logic                      clear,
  output logic [CHANNELS-1:0]       y_out,
  output logic [CHANNELS*CNT_W-1:0] run_len,
  output logic [HIT_W-1:0]          hit_count
);

  logic [CHANNELS-1:0] hit;
  logic [31:0]         pop;
  logic [HIT_W-1:0]    hit_count_q, hit_count_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    run_len_channel #(
      .MIN_RUN (MIN_RUN),
      .CNT_W   (CNT_W),
      .REG_OUT (REG_OUT)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .x_valid (x_valid),
      .x_bit   (x_in[c]),
      .hit     (hit[c]),
      .y       (y_out[c]),
      .run_len (run_len[c*CNT_W +: CNT_W])
    );
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < CHANNELS; c++)
      pop = pop + 32'(hit[c]);
    if (clear)
      hit_count_d = '0;
    else
      hit_count_d = HIT_W'(sat_add(32'(hit_count_q), pop, HIT_W));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hit_count_q <= '0;
    else        hit_count_q <= hit_count_d;
  end

  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_multi_channel_run_detector.sv
// Directed bench: three detector configurations share one
// stimulus stream and are checked against a reference model.
module tb_multi_channel_run_detector;

  logic       clock;
  logic       reset;
  logic       x_valid;
  logic [3:0] x_in;
  logic       clear;

  logic [3:0]  y_a, y_b, y_c;
  logic [15:0] rl_a, rl_b, rl_c;
  logic [7:0]  hc_a, hc_c;
  logic [1:0]  hc_b;

  // A: classic Mealy; B: MIN_RUN=3, 2-bit counter; C: registered
  multi_channel_run_detector #(
    .CHANNELS(4), .MIN_RUN(1), .CNT_W(4), .REG_OUT(1'b0), .HIT_W(8)
  ) dut_a (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in),
    .clear(clear), .y_out(y_a), .run_len(rl_a), .hit_count(hc_a)
  );

  multi_channel_run_detector #(
    .CHANNELS(4), .MIN_RUN(3), .CNT_W(4), .REG_OUT(1'b0), .HIT_W(2)
  ) dut_b (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in),
    .clear(clear), .y_out(y_b), .run_len(rl_b), .hit_count(hc_b)
  );

  multi_channel_run_detector #(
    .CHANNELS(4), .MIN_RUN(1), .CNT_W(4), .REG_OUT(1'b1), .HIT_W(8)
  ) dut_c (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x_in(x_in),
    .clear(clear), .y_out(y_c), .run_len(rl_c), .hit_count(hc_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0][15:0] rl;
    logic [2:0][7:0]  hc;
    logic [3:0]       yc;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int fails = 0;

  int mcnt[3][4];
  int mrl[3][4];
  int mhc[3];
  logic [3:0] myc;
  int minrun[3] = '{1, 3, 1};
  int hmax[3]   = '{255, 3, 255};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mhc[i] = 0;
      for (int c = 0; c < 4; c++) begin
        mcnt[i][c] = 0;
        mrl[i][c]  = 0;
      end
    end
    myc = '0;
  endtask

  function automatic logic [15:0] pack_rl(input int i);
    logic [15:0] v;
    for (int c = 0; c < 4; c++)
      v[c*4 +: 4] = 4'(mrl[i][c]);
    return v;
  endfunction

  task automatic step(input logic xv, input logic [3:0] xi,
                      input logic clr, input string tag);
    logic [2:0][3:0] h;
    int   pc;
    exp_t e;
    @(negedge clock);
    x_valid = xv;
    x_in    = xi;
    clear   = clr;
    #1;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 4; c++)
        h[i][c] = xv && !xi[c] && (mcnt[i][c] >= minrun[i]);
    chk({tag, "_ya"}, 32'(y_a), 32'(h[0]));
    chk({tag, "_yb"}, 32'(y_b), 32'(h[1]));
    chk({tag, "_yc"}, 32'(y_c), 32'(myc));
    for (int i = 0; i < 3; i++) begin
      pc = 0;
      for (int c = 0; c < 4; c++) begin
        if (h[i][c]) begin
          mrl[i][c] = mcnt[i][c];
          pc++;
        end
        if (xv)
          mcnt[i][c] = xi[c] ? ((mcnt[i][c] < 15) ? mcnt[i][c] + 1 : 15) : 0;
      end
      if (clr) mhc[i] = 0;
      else     mhc[i] = (mhc[i] + pc > hmax[i]) ? hmax[i] : mhc[i] + pc;
      e.rl[i] = pack_rl(i);
      e.hc[i] = 8'(mhc[i]);
    end
    myc  = h[2];
    e.yc = myc;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rl_a"}, 32'(rl_a), 32'(e.rl[0]));
      chk({tag, "_rl_b"}, 32'(rl_b), 32'(e.rl[1]));
      chk({tag, "_rl_c"}, 32'(rl_c), 32'(e.rl[2]));
      chk({tag, "_hc_a"}, 32'(hc_a), 32'(e.hc[0]));
      chk({tag, "_hc_b"}, 32'(hc_b), 32'(e.hc[1]));
      chk({tag, "_hc_c"}, 32'(hc_c), 32'(e.hc[2]));
      chk({tag, "_yc_reg"}, 32'(y_c), 32'(e.yc));
    end
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic async_reset(input string tag);
    #2;
    x_valid = 1'b1;
    x_in    = 4'h0;
    clear   = 1'b0;
    reset   = 1'b0;
    #1;
    model_reset();
    chk({tag, "_y_a"}, 32'(y_a), 32'd0);
    chk({tag, "_y_b"}, 32'(y_b), 32'd0);
    chk({tag, "_y_c"}, 32'(y_c), 32'd0);
    chk({tag, "_rl_a"}, 32'(rl_a), 32'd0);
    chk({tag, "_rl_c"}, 32'(rl_c), 32'd0);
    chk({tag, "_hc_a"}, 32'(hc_a), 32'd0);
    chk({tag, "_hc_b"}, 32'(hc_b), 32'd0);
    @(negedge clock);
    x_valid = 1'b0;
    reset   = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    x_valid = 1'b0;
    x_in    = 4'h0;
    clear   = 1'b0;
    model_reset();
    #3;
    chk("rst_y_a", 32'(y_a), 32'd0);
    chk("rst_y_c", 32'(y_c), 32'd0);
    chk("rst_rl_a", 32'(rl_a), 32'd0);
    chk("rst_hc_a", 32'(hc_a), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // zero detector, ch0: 0,1,1,0,0
    step(1, 4'h0, 0, "t1_0");
    step(1, 4'h1, 0, "t1_1");
    step(1, 4'h1, 0, "t1_2");
    step(1, 4'h0, 0, "t1_3");
    chk("t1_runlen_a", 32'(rl_a[3:0]), 32'd2);
    chk("t1_yc_delayed", 32'(y_c[0]), 32'd1);
    step(1, 4'h0, 0, "t1_4");

    // MIN_RUN=3 on ch1: short run, then a qualifying run
    async_reset("t2_rst");
    step(1, 4'h2, 0, "t2_0");
    step(1, 4'h2, 0, "t2_1");
    step(1, 4'h0, 0, "t2_2");
    step(1, 4'h2, 0, "t2_3");
    step(1, 4'h2, 0, "t2_4");
    step(1, 4'h2, 0, "t2_5");
    step(1, 4'h0, 0, "t2_6");
    chk("t2_runlen_b", 32'(rl_b[7:4]), 32'd3);
    chk("t2_hc_b", 32'(hc_b), 32'd1);

    // saturation of run counter and of the 2-bit hit counter
    async_reset("t3_rst");
    for (int k = 0; k < 20; k++) step(1, 4'h1, 0, "t3_ones");
    step(1, 4'h0, 0, "t3_zero");
    chk("t3_runlen_sat", 32'(rl_a[3:0]), 32'd15);
    for (int n = 0; n < 4; n++) begin
      step(1, 4'h1, 0, "t3_r");
      step(1, 4'h1, 0, "t3_r");
      step(1, 4'h1, 0, "t3_r");
      step(1, 4'h0, 0, "t3_h");
    end
    chk("t3_hc_b_sat", 32'(hc_b), 32'd3);

    // all channels hit together, then with clear on the hit cycle
    step(1, 4'hf, 0, "t4_1");
    step(1, 4'h0, 0, "t4_0");
    step(1, 4'hf, 0, "t4_1c");
    step(1, 4'h0, 1, "t4_0c");
    chk("t4_hc_a_clear", 32'(hc_a), 32'd0);

    // registered output and gaps inside a run
    async_reset("t5_rst");
    step(1, 4'h1, 0, "t5_0");
    step(0, 4'h0, 0, "t5_gap");
    step(1, 4'h1, 0, "t5_1");
    step(0, 4'h0, 0, "t5_gap");
    step(1, 4'h1, 0, "t5_2");
    step(1, 4'h0, 0, "t5_hit");
    chk("t5_runlen_c", 32'(rl_c[3:0]), 32'd3);
    step(1, 4'h0, 0, "t5_tail");

    // reset mid-run discards the run
    step(1, 4'h1, 0, "t6_1");
    step(1, 4'h1, 0, "t6_1");
    step(1, 4'h1, 0, "t6_1");
    async_reset("t6_rst");
    step(1, 4'h0, 0, "t6_after");
    chk("t6_no_hit", 32'(hc_a), 32'd0);

    if (exp_q.size() != 0) chk("tail_queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
